// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: DATA/CTRL/STATUS registers, programmable SCLK
// divider, CPOL/CPHA, bit order, per-transfer length from byte selects and
// an optional held chip select that spans several transfers.
module wb_spi_master #(
  parameter int unsigned NUM_CS  = 3,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned RST_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       adr_i,
  input  logic [31:0]       dat_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  output logic              ack_o,
  output logic [31:0]       dat_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned LEN_W = 6;

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   hp_q, hp_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DW-1:0]      tx_q, tx_d;
  logic [DW-1:0]      rxsh_q, rxsh_d;
  logic [DW-1:0]      rx_q, rx_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic               mosi_q, mosi_d;
  logic               sclk_q, sclk_d;
  logic               ack_q, ack_d;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               lsb_q, lsb_d;
  logic [2:0]         csidx_q, csidx_d;
  logic               cshold_q, cshold_d;

  logic               req_c, start_c, hp_end_c, last_hp_c;
  logic               edge_c, lead_c, sample_c, adv_c;
  logic               busy_c, cs_active_c;
  logic [1:0]         reg_sel_c;
  logic [LEN_W-1:0]   wr_len_c;
  logic [DW-1:0]      tx_al_c, ctrl_rd_c, rdata_c;
  logic [LEN_W:0]     two_n_m1_c;
  logic               unused_c;

  // Bit-reverse a word so that dat_i[0] lands at the shift-out position.
  function automatic logic [DW-1:0] rev32(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Active-low one-hot chip select; an out-of-range index selects nothing.
  function automatic logic [NUM_CS-1:0] cs_dec(input logic [2:0] idx);
    logic [NUM_CS-1:0] r;
    for (int i = 0; i < NUM_CS; i++) r[i] = (idx != 3'(i));
    return r;
  endfunction

  assign unused_c = ^{adr_i[31:4], adr_i[1:0]};

  // Bus decode, transfer-length, timing and SPI edge classification.
  always_comb begin
    reg_sel_c   = adr_i[3:2];
    req_c       = stb_i & cyc_i & ~ack_q;
    busy_c      = (state_q != S_IDLE);
    cs_active_c = ~(&cs_n_q);
    case (sel_i)
      4'b1111: wr_len_c = LEN_W'(32);
      4'b0011: wr_len_c = LEN_W'(16);
      4'b0001: wr_len_c = LEN_W'(8);
      default: wr_len_c = '0;
    endcase
    start_c    = (state_q == S_IDLE) & req_c & we_i & (reg_sel_c == 2'd0) & (wr_len_c != '0);
    tx_al_c    = lsb_q ? rev32(dat_i) : (dat_i << (LEN_W'(32) - wr_len_c));
    hp_end_c   = (cnt_q == div_q);
    two_n_m1_c = {len_q, 1'b0} - (LEN_W+1)'(1);
    last_hp_c  = ({1'b0, hp_q} == two_n_m1_c);
    edge_c     = 1'b0;
    lead_c     = 1'b0;
    if (state_q == S_LEAD && hp_end_c) begin
      edge_c = 1'b1;
      lead_c = 1'b1;
    end else if (state_q == S_SHIFT && hp_end_c && !last_hp_c) begin
      edge_c = 1'b1;
      lead_c = hp_q[0];
    end
    sample_c = edge_c & (lead_c ^ cpha_q);
    adv_c    = edge_c & ~(lead_c ^ cpha_q);

    ctrl_rd_c            = '0;
    ctrl_rd_c[DIV_W-1:0] = div_q;
    ctrl_rd_c[16]        = cpol_q;
    ctrl_rd_c[17]        = cpha_q;
    ctrl_rd_c[18]        = lsb_q;
    ctrl_rd_c[26:24]     = csidx_q;
    ctrl_rd_c[27]        = cshold_q;
    case (reg_sel_c)
      2'd0:    rdata_c = rx_q;
      2'd1:    rdata_c = ctrl_rd_c;
      2'd2:    rdata_c = {30'd0, cs_active_c, busy_c};
      default: rdata_c = '0;
    endcase
  end

  // Next-state logic for the transfer FSM and all registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    len_d    = len_q;
    tx_d     = tx_q;
    rxsh_d   = rxsh_q;
    rx_d     = rx_q;
    dat_d    = dat_q;
    mosi_d   = mosi_q;
    sclk_d   = sclk_q;
    ack_d    = 1'b0;
    cs_n_d   = cs_n_q;
    div_d    = div_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    csidx_d  = csidx_q;
    cshold_d = cshold_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol_q;
        mosi_d = 1'b0;
        if (start_c) begin
          state_d = S_LEAD;
          cnt_d   = '0;
          hp_d    = '0;
          len_d   = wr_len_c;
          rxsh_d  = '0;
          cs_n_d  = cs_dec(csidx_q);
          if (cpha_q) begin
            tx_d = tx_al_c;
          end else begin
            mosi_d = tx_al_c[31];
            tx_d   = {tx_al_c[30:0], 1'b0};
          end
        end else if (req_c) begin
          ack_d = 1'b1;
          dat_d = we_i ? '0 : rdata_c;
          if (we_i && reg_sel_c == 2'd1) begin
            div_d    = dat_i[DIV_W-1:0];
            cpol_d   = dat_i[16];
            cpha_d   = dat_i[17];
            lsb_d    = dat_i[18];
            csidx_d  = dat_i[26:24];
            cshold_d = dat_i[27];
            if (cs_active_c && (!dat_i[27] || dat_i[26:24] != csidx_q)) cs_n_d = '1;
          end
        end
      end
      S_LEAD: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (hp_end_c) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          sclk_d  = ~cpol_q;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (hp_end_c) begin
          cnt_d = '0;
          if (last_hp_c) begin
            state_d = S_TRAIL;
          end else begin
            hp_d   = hp_q + LEN_W'(1);
            sclk_d = ~sclk_q;
          end
        end
      end
      S_TRAIL: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (hp_end_c) begin
          state_d = S_DONE;
          mosi_d  = 1'b0;
          rx_d    = lsb_q ? (rxsh_q >> (LEN_W'(32) - len_q)) : rxsh_q;
          if (!cshold_q) cs_n_d = '1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ack_d   = stb_i & cyc_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (sample_c) rxsh_d = lsb_q ? {spi_miso_i, rxsh_q[31:1]} : {rxsh_q[30:0], spi_miso_i};
    if (adv_c) begin
      mosi_d = tx_q[31];
      tx_d   = {tx_q[30:0], 1'b0};
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hp_q     <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      rxsh_q   <= '0;
      rx_q     <= '0;
      dat_q    <= '0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      ack_q    <= 1'b0;
      cs_n_q   <= '1;
      div_q    <= DIV_W'(RST_DIV);
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      csidx_q  <= '0;
      cshold_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      rxsh_q   <= rxsh_d;
      rx_q     <= rx_d;
      dat_q    <= dat_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      ack_q    <= ack_d;
      cs_n_q   <= cs_n_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      csidx_q  <= csidx_d;
      cshold_q <= cshold_d;
    end
  end

  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Bench for wb_spi_master: vector table of bus operations with hand-computed
// ack latencies and read data, SPI line monitor, plus corner-case sequences.
module tb_wb_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr_i, dat_i;
  logic        we_i, stb_i, cyc_i;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        spi_sclk_o, spi_mosi_o, spi_miso_i;
  logic [2:0]  spi_cs_n_o;

  wb_spi_master #(.NUM_CS(3), .DIV_W(8), .RST_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .adr_i(adr_i), .dat_i(dat_i), .we_i(we_i), .sel_i(sel_i),
    .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .dat_o(dat_o),
    .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso_i), .spi_cs_n_o(spi_cs_n_o)
  );

  always #5 clk = ~clk;
  assign spi_miso_i = spi_mosi_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Bench model of CTRL
  int       m_h = 2;
  logic     m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_hold = 1'b0;
  logic [2:0] m_idx = 3'd0;
  logic     m_xfer = 1'b0;

  // Monitor history
  int       tog_total = 0, lead_total = 0, bad_total = 0;
  logic     bit_hist [4096];
  logic [2:0] cs_hist [4096];
  logic [2:0] cs_at_ack;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          lat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          n;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // SCLK/MOSI/CS monitor, sampled 1 time unit after each rising clk edge
  initial begin
    logic sclk_prev, mosi_prev;
    int   cyc, last_tog;
    sclk_prev = 1'b0;
    mosi_prev = 1'b0;
    cyc = 0;
    last_tog = -100000;
    forever begin
      @(posedge clk);
      #1;
      if (m_xfer && spi_sclk_o !== sclk_prev) begin
        tog_total++;
        if ((cyc - last_tog) != m_h && (cyc - last_tog) < 2 * m_h + 2) bad_total++;
        last_tog = cyc;
        if (spi_sclk_o !== m_cpol && lead_total < 4096) begin
          bit_hist[lead_total] = m_cpha ? spi_mosi_o : mosi_prev;
          cs_hist[lead_total]  = spi_cs_n_o;
          lead_total++;
        end
      end
      sclk_prev = spi_sclk_o;
      mosi_prev = spi_mosi_o;
      cyc++;
    end
  end

  task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                     input logic [3:0] sel, output int cnt, output logic [31:0] rd);
    @(negedge clk);
    adr_i = adr; dat_i = dat; we_i = we; sel_i = sel;
    stb_i = 1'b1; cyc_i = 1'b1;
    m_xfer = we && (adr[3:2] == 2'd0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (ack_o !== 1'b1 && cnt < 3000);
    rd = dat_o;
    cs_at_ack = spi_cs_n_o;
    @(negedge clk);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    m_xfer = 1'b0;
    if (we && adr[3:2] == 2'd1) begin
      m_h    = int'(dat[7:0]) + 1;
      m_cpol = dat[16];
      m_cpha = dat[17];
      m_lsb  = dat[18];
      m_idx  = dat[26:24];
      m_hold = dat[27];
    end
  endtask

  initial begin
    int          cnt, snap_tog, snap_lead, snap_bad, acks;
    logic [31:0] rd, got_w, exp_w;
    logic [2:0]  exp_cs;
    vec_t        v;

    //            adr    dat            we    sel      lat  chk   exp_rd        n
    vecs[0]  = '{32'h4, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000001,  0};
    vecs[1]  = '{32'h8, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[2]  = '{32'h0, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[3]  = '{32'hC, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[4]  = '{32'h4, 32'hFFFFFFFF,  1'b1, 4'hF,    1, 1'b0, 32'h0,         0};
    vecs[5]  = '{32'h4, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h0F0700FF,  0};
    vecs[6]  = '{32'hC, 32'hDEADBEEF,  1'b1, 4'hF,    1, 1'b0, 32'h0,         0};
    vecs[7]  = '{32'hC, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[8]  = '{32'h4, 32'h00000001,  1'b1, 4'hF,    1, 1'b0, 32'h0,         0};
    vecs[9]  = '{32'h0, 32'h000000FF,  1'b1, 4'b0100, 1, 1'b0, 32'h0,         0};
    vecs[10] = '{32'h0, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[11] = '{32'h0, 32'h000000A5,  1'b1, 4'b0001, 38, 1'b0, 32'h0,        8};
    vecs[12] = '{32'h0, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h000000A5,  0};
    vecs[13] = '{32'h8, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00000000,  0};
    vecs[14] = '{32'h0, 32'hDEADBEEF,  1'b1, 4'hF,  134, 1'b0, 32'h0,        32};
    vecs[15] = '{32'h0, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'hDEADBEEF,  0};
    vecs[16] = '{32'h4, 32'h00070000,  1'b1, 4'hF,    1, 1'b0, 32'h0,         0};
    vecs[17] = '{32'h4, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00070000,  0};
    vecs[18] = '{32'h0, 32'hFFFF1234,  1'b1, 4'b0011, 36, 1'b0, 32'h0,       16};
    vecs[19] = '{32'h0, 32'h0,         1'b0, 4'hF,    1, 1'b1, 32'h00001234,  0};
    vecs[20] = '{32'h0, 32'h0000005A,  1'b1, 4'b0001, 20, 1'b0, 32'h0,        8};

    rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; sel_i = '0; stb_i = 1'b0; cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, ack_o}, 32'd0);
    chk("reset_cs_n", {29'd0, spi_cs_n_o}, 32'h7);
    chk("reset_sclk", {31'd0, spi_sclk_o}, 32'd0);
    chk("reset_mosi", {31'd0, spi_mosi_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      v = vecs[i];
      snap_tog = tog_total; snap_lead = lead_total; snap_bad = bad_total;
      exp_cs = (m_idx < 3'd3) ? ~(3'b001 << m_idx) : 3'b111;
      bus(v.adr, v.dat, v.we, v.sel, cnt, rd);
      chk($sformatf("v%0d_ack_latency", i), 32'(cnt), 32'(v.lat));
      if (v.chk_rd) chk($sformatf("v%0d_rdata", i), rd, v.exp_rd);
      if (v.we && v.adr[3:2] == 2'd0) begin
        chk($sformatf("v%0d_sclk_toggles", i), 32'(tog_total - snap_tog), 32'(2 * v.n));
        chk($sformatf("v%0d_half_period", i), 32'(bad_total - snap_bad), 32'd0);
        if (v.n > 0) begin
          got_w = '0; exp_w = '0;
          for (int k = 0; k < v.n; k++) begin
            got_w[k] = bit_hist[snap_lead + k];
            exp_w[k] = m_lsb ? v.dat[k] : v.dat[v.n - 1 - k];
          end
          chk($sformatf("v%0d_mosi_bits", i), got_w, exp_w);
          chk($sformatf("v%0d_cs_during", i), {29'd0, cs_hist[snap_lead]}, {29'd0, exp_cs});
          chk($sformatf("v%0d_cs_after", i), {29'd0, cs_at_ack}, 32'h7);
        end
      end
    end

    // SCLK idles at cpol=1
    #1;
    chk("sclk_idle_cpol1", {31'd0, spi_sclk_o}, 32'd1);

    // Held chip select across two transfers, released by a CTRL write
    bus(32'h4, 32'h0A000000, 1'b1, 4'hF, cnt, rd);
    bus(32'h0, 32'h12345678, 1'b1, 4'hF, cnt, rd);
    chk("hold_lat1", 32'(cnt), 32'd68);
    chk("hold_cs_after1", {29'd0, cs_at_ack}, 32'h3);
    bus(32'h8, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("hold_status", rd, 32'h2);
    chk("hold_cs_idle", {29'd0, spi_cs_n_o}, 32'h3);
    snap_lead = lead_total;
    bus(32'h0, 32'h87654321, 1'b1, 4'hF, cnt, rd);
    chk("hold_cs_during2", {29'd0, cs_hist[snap_lead]}, 32'h3);
    chk("hold_cs_after2", {29'd0, cs_at_ack}, 32'h3);
    bus(32'h4, 32'h02000000, 1'b1, 4'hF, cnt, rd);
    chk("hold_release", {29'd0, cs_at_ack}, 32'h7);

    // Out-of-range chip select: clock still runs, no CS asserts
    bus(32'h4, 32'h05000000, 1'b1, 4'hF, cnt, rd);
    snap_tog = tog_total; snap_lead = lead_total;
    bus(32'h0, 32'h000000C3, 1'b1, 4'b0001, cnt, rd);
    chk("bad_idx_lat", 32'(cnt), 32'd20);
    chk("bad_idx_toggles", 32'(tog_total - snap_tog), 32'd16);
    chk("bad_idx_cs_during", {29'd0, cs_hist[snap_lead]}, 32'h7);

    // Master abandons the cycle: transfer completes, no ack
    bus(32'h4, 32'h00000001, 1'b1, 4'hF, cnt, rd);
    snap_tog = tog_total;
    @(negedge clk);
    adr_i = 32'h0; dat_i = 32'h0000003C; we_i = 1'b1; sel_i = 4'b0001;
    stb_i = 1'b1; cyc_i = 1'b1; m_xfer = 1'b1;
    @(negedge clk);
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    acks = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (ack_o === 1'b1) acks++;
    end
    m_xfer = 1'b0;
    chk("drop_cyc_acks", 32'(acks), 32'd0);
    chk("drop_cyc_toggles", 32'(tog_total - snap_tog), 32'd16);
    bus(32'h0, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("drop_cyc_rdata", rd, 32'h0000003C);
    bus(32'h8, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("drop_cyc_status", rd, 32'h0);

    // Reset in the middle of a 32-bit shift
    @(negedge clk);
    adr_i = 32'h0; dat_i = 32'hFFFFFFFF; we_i = 1'b1; sel_i = 4'hF;
    stb_i = 1'b1; cyc_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_cs_n", {29'd0, spi_cs_n_o}, 32'h7);
    chk("rst_mid_sclk", {31'd0, spi_sclk_o}, 32'd0);
    chk("rst_mid_mosi", {31'd0, spi_mosi_o}, 32'd0);
    chk("rst_mid_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    m_h = 2; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_idx = 3'd0; m_hold = 1'b0;
    bus(32'h8, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("rst_mid_status", rd, 32'h0);
    bus(32'h4, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("rst_mid_ctrl", rd, 32'h1);
    bus(32'h0, 32'h0, 1'b0, 4'hF, cnt, rd);
    chk("rst_mid_rx", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
